// File: rtl/uart_sample_framer.sv
`default_nettype none
// ============================================================================
// uart_sample_framer
// Splits each channel of a captured sample into tagged CHUNK_W-bit bytes behind
// a sync byte and sends them 8N1 (8E1 with UART_SAMPLE_FRAMER_PARITY_EN).
// Revision: 1.0
// ============================================================================
module uart_sample_framer #(
  parameter int DATA_W  = 12,
  parameter int CHUNK_W = 6,
  parameter int NUM_CH  = 1,
  parameter int CLK_DIV = 278
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     txd,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     drop_o
);

  localparam int TAG_W      = 8 - CHUNK_W;
  localparam int NUM_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam int NUM_BYTES  = 1 + NUM_CH * NUM_CHUNKS;
  localparam int CNT_W      = $clog2(CLK_DIV);
  localparam int BIDX_W     = $clog2(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_SAMPLE_FRAMER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
  logic [BIDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]          div_cnt_q, div_cnt_d;
  logic [CHUNK_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                      done_q, done_d;

  logic                      div_last;
  logic                      bit_last;
  logic                      byte_last;
  logic [7:0]                cur_byte;
  logic [7:0]                frame_bytes [NUM_BYTES];

  // Byte 0 is the sync byte; the rest are laid out channel-major, MSB chunk first.
  assign frame_bytes[0] = {TAG_W'(0), frame_cnt_q};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PAD_W-1:0] pad;
    assign pad = PAD_W'(data_q[c*DATA_W +: DATA_W]);
    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
      assign frame_bytes[1 + c*NUM_CHUNKS + k] =
        {TAG_W'(NUM_CHUNKS - k), pad[(NUM_CHUNKS-1-k)*CHUNK_W +: CHUNK_W]};
    end
  end

  assign cur_byte  = frame_bytes[byte_idx_q];
  assign div_last  = (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign bit_last  = (bit_idx_q == 3'd7);
  assign byte_last = (byte_idx_q == BIDX_W'(NUM_BYTES - 1));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    div_cnt_d   = (state_q == S_IDLE || div_last) ? '0 : div_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d    = S_START;
          data_d     = data_i;
          byte_idx_d = '0;
        end
      end
      S_START: begin
        if (div_last) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (div_last) begin
          if (bit_last) begin
`ifdef UART_SAMPLE_FRAMER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_SAMPLE_FRAMER_PARITY_EN
      S_PARITY: begin
        if (div_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Next byte starts straight after the stop bit, with no idle gap.
        if (div_last) begin
          if (byte_last) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + CHUNK_W'(1);
          end else begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = cur_byte[bit_idx_q];
`ifdef UART_SAMPLE_FRAMER_PARITY_EN
      S_PARITY: txd = ^cur_byte;
`endif
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      div_cnt_q   <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      div_cnt_q   <= div_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign busy_o       = ~ready_o;
  assign frame_done_o = done_q;
  assign drop_o       = valid_i & ~ready_o;

endmodule

`default_nettype wire

// File: tb/tb_uart_sample_framer.sv
`default_nettype none
// ============================================================================
// tb_uart_sample_framer
// Scoreboard bench: a UART decoder on txd is checked against frames predicted
// from the byte-layout rules, plus frame_done/drop/ready timing.
// Revision: 1.0
// ============================================================================
module tb_uart_sample_framer;

  localparam int DATA_W  = 10;
  localparam int CHUNK_W = 6;
  localparam int NUM_CH  = 2;
  localparam int CLK_DIV = 4;
  localparam int TOT_W   = NUM_CH * DATA_W;
  localparam int NC      = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int NB      = 1 + NUM_CH * NC;
`ifdef UART_SAMPLE_FRAMER_PARITY_EN
  localparam int BITS    = 11;
`else
  localparam int BITS    = 10;
`endif
  localparam int BYTE_T  = BITS * CLK_DIV;
  localparam int F       = NB * BYTE_T;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [TOT_W-1:0] data = '0;
  logic             valid = 1'b0;
  logic             ready_o, txd, busy_o, frame_done_o, drop_o;

  uart_sample_framer #(
    .DATA_W (DATA_W),
    .CHUNK_W(CHUNK_W),
    .NUM_CH (NUM_CH),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk_i       (clk),
    .rst         (rst),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready_o),
    .txd         (txd),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .drop_o      (drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  int         drop_q[$];
  logic [7:0] dec_log[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_end = 0;
  int   frames = 0;
  logic exp_ready = 1'b1;

  task automatic chk(input string nm, input longint got, input longint expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, got, expv);
    end
  endtask

  // Reference model: byte values from the tag/chunk rules, timing from frame arithmetic.
  task automatic push_frame(input logic [TOT_W-1:0] d, input int cap);
    exp_t   e;
    longint v;
    int     idx;
    e.b = 8'(frames % (1 << CHUNK_W));
    e.start = cap + 1;
    exp_q.push_back(e);
    idx = 1;
    for (int c = 0; c < NUM_CH; c++) begin
      v = longint'(d >> (c * DATA_W)) & ((64'd1 << DATA_W) - 1);
      for (int k = 0; k < NC; k++) begin
        e.b = 8'(((NC - k) << CHUNK_W) | ((v >> ((NC - 1 - k) * CHUNK_W)) & ((1 << CHUNK_W) - 1)));
        e.start = cap + 1 + idx * BYTE_T;
        exp_q.push_back(e);
        idx++;
      end
    end
    done_q.push_back(cap + F + 1);
    busy_end = cap + F;
    frames++;
  endtask

  task automatic step(input logic v, input logic [TOT_W-1:0] d, input logic r);
    @(posedge clk);
    #1;
    rst   = r;
    valid = v;
    data  = d;
    if (r) begin
      exp_q.delete();
      done_q.delete();
      drop_q.delete();
      busy_end  = cyc;
      frames    = 0;
      exp_ready = 1'b1;
    end else begin
      exp_ready = (cyc > busy_end);
      if (v) begin
        if (exp_ready) push_frame(d, cyc);
        else drop_q.push_back(cyc);
      end
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc <= busy_end + 1 && guard < 4 * F) begin
      step(1'b0, '0, 1'b0);
      guard++;
    end
    if (guard >= 4 * F) chk("idle_timeout", guard, 0);
  endtask

  task automatic chk_log(input int idx, input logic [7:0] e);
    chk("decoded_byte", (idx < dec_log.size()) ? longint'(dec_log[idx]) : 64'hFFFF, e);
  endtask

  // Monitor: UART decoder sampling mid-bit, plus frame_done/drop/ready checks.
  logic       dec_on = 1'b0;
  int         dec_off, dec_start, dec_j;
  logic [7:0] dec_byte;
  logic       dec_start_bit, dec_par;
  exp_t       e_pop;

  always @(negedge clk) begin
    if (rst) begin
      dec_on = 1'b0;
    end else begin
      chk("ready", ready_o, exp_ready);
      chk("busy", busy_o, !exp_ready);
      if (frame_done_o) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (drop_o) begin
        if (drop_q.size() == 0) chk("drop_unexpected", 1, 0);
        else chk("drop_cycle", cyc, drop_q.pop_front());
      end
      if (!dec_on) begin
        if (txd == 1'b0) begin
          dec_on    = 1'b1;
          dec_off   = 0;
          dec_start = cyc;
          dec_byte  = '0;
        end
      end else begin
        dec_off++;
      end
      if (dec_on && (dec_off % CLK_DIV) == CLK_DIV / 2) begin
        dec_j = dec_off / CLK_DIV;
        if (dec_j == 0) dec_start_bit = txd;
        else if (dec_j <= 8) dec_byte[dec_j - 1] = txd;
        else if (dec_j < BITS - 1) dec_par = txd;
        else begin
          dec_on = 1'b0;
          dec_log.push_back(dec_byte);
          chk("stop_bit", txd, 1);
          chk("start_bit", dec_start_bit, 0);
          if (exp_q.size() == 0) begin
            chk("byte_unexpected", dec_byte, 9'h100);
          end else begin
            e_pop = exp_q.pop_front();
            chk("byte_value", dec_byte, e_pop.b);
            chk("byte_start", dec_start, e_pop.start);
`ifdef UART_SAMPLE_FRAMER_PARITY_EN
            chk("parity_bit", dec_par, ^e_pop.b);
`endif
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int target;
    logic [TOT_W-1:0] d;

    // Reset state
    repeat (3) step(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_drop", drop_o, 0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Two frames back-to-back with valid held high; ch0 exercises MSB padding
    base = dec_log.size();
    d = {10'h001, 10'h3FF};
    while (frames < 2) step(1'b1, d, 1'b0);
    wait_idle();
    chk_log(base + 0, 8'h00);
    chk_log(base + 1, 8'h8F);
    chk_log(base + 2, 8'h7F);
    chk_log(base + 3, 8'h80);
    chk_log(base + 4, 8'h41);
    chk_log(base + 5, 8'h01);
    @(negedge clk);
    chk("txd_idle_after", txd, 1);

    // Overrun: three valid pulses while a frame is in flight
    step(1'b1, TOT_W'($urandom), 1'b0);
    for (int i = 0; i < 3 * F / 4; i++)
      step((i % (F / 4)) == 10, TOT_W'($urandom), 1'b0);
    wait_idle();

    // Reset during data bit 3 of byte 1
    step(1'b1, TOT_W'($urandom), 1'b0);
    target = cyc + 1 + BYTE_T + 4 * CLK_DIV + 1;
    while (cyc + 1 < target) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("midrst_txd", txd, 1);
    chk("midrst_ready", ready_o, 1);
    base = dec_log.size();
    step(1'b1, TOT_W'($urandom), 1'b0);
    wait_idle();
    chk_log(base, 8'h00);

    // Randomised frames with random gaps and stray valid pulses
    for (int it = 0; it < 15; it++) begin
      while (cyc + 1 <= busy_end)
        step($urandom_range(0, 19) == 0, TOT_W'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) step(1'b0, '0, 1'b0);
      step(1'b1, TOT_W'($urandom), 1'b0);
    end
    wait_idle();
    step(1'b0, '0, 1'b0);

    chk("bytes_pending", exp_q.size(), 0);
    chk("done_pending", done_q.size(), 0);
    chk("drop_pending", drop_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_sample_framer.md
Name: uart_sample_framer

Overview:
- Parametrised successor to the 12-bit, two-packet UART sample sender.
- Captures a multi-channel sample word through a valid/ready handshake and splits each channel into tagged CHUNK_W-bit packets, MSB chunk first.
- Prefixes each frame with a sync byte and serialises everything on an internal 8N1 transmitter at CLK_DIV clocks per bit.
- Sits between the ADC/sample logic and the board txd pin; replaces the external divider plus free-running packet toggle.

Parameters:
- DATA_W, 12: bits per channel sample (1..CHUNK_W*(2^TAG_W-1)).
- CHUNK_W, 6: payload bits per byte; TAG_W = 8-CHUNK_W (default 2).
- NUM_CH, 1: channels per frame (1..8).
- CLK_DIV, 278: clk_i cycles per UART bit (>=2); 278 gives ~115200 baud at 32 MHz.

Ports:
- clk_i  in  1  system clock
- rst  in  1  synchronous active-high reset
- data_i  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- valid_i  in  1  sample valid
- ready_o  out  1  framer idle, sample accepted when valid_i&ready_o
- txd  out  1  UART serial output, idle high
- busy_o  out  1  frame in progress (= ~ready_o)
- frame_done_o  out  1  one-cycle pulse after the last stop bit
- drop_o  out  1  one-cycle pulse when valid_i=1 and ready_o=0 (sample lost)

Behaviour:
- Reset (synchronous, on rising clk_i while rst=1):
  - txd=1, ready_o=1, busy_o=0, frame_done_o=0, drop_o=0.
  - Frame counter=0, FSM=IDLE.
  - Reset mid-frame aborts at the next edge; txd returns high immediately, with no partial stop bit.
- NUM_CHUNKS = ceil(DATA_W/CHUNK_W). Each sample is zero-extended at the MSB to NUM_CHUNKS*CHUNK_W bits.
- Byte k of a channel (k=0 is the MSB chunk) = {tag, chunk}, with tag = NUM_CHUNKS-k. The last chunk therefore always has tag 1. Tag 0 is reserved for sync.
- Frame byte order:
  - Sync byte {TAG_W'b0, frame_cnt[CHUNK_W-1:0]}.
  - Then ch0 chunks, ch1 chunks, ... ch(NUM_CH-1) chunks.
  - Total 1+NUM_CH*NUM_CHUNKS bytes.
- FSM states:
  - IDLE: ready_o=1. On valid_i, register the full data_i word, ready_o drops next cycle, go to START.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each.
  - STOP: txd=1 for CLK_DIV cycles. If more bytes remain, load the next byte and go to START with no idle gap. Otherwise go to IDLE.
- Timing:
  - The start bit of the sync byte begins in the cycle after the capture cycle.
  - Byte time = 10*CLK_DIV cycles.
  - Frame time F = (1+NUM_CH*NUM_CHUNKS)*10*CLK_DIV cycles from the first start-bit cycle to the end of the last stop bit.
- End of frame: in the cycle after the last stop bit ends, ready_o=1 and frame_done_o=1 for one cycle. frame_cnt increments (mod 2^CHUNK_W) at that point.
- Back-to-back frames: valid_i held high is accepted in that same ready cycle. The next start bit follows one cycle later, so there is exactly one idle-high cycle between frames.
- Data stability: data_i is sampled only at capture. Later changes do not affect the frame in flight.
- drop_o pulses every cycle in which valid_i=1 and ready_o=0. There is no buffering.
- The bit counter is $clog2(CLK_DIV) wide and wraps to 0 at CLK_DIV-1. The byte index is sized for NUM_CH*NUM_CHUNKS.

Optional Feature:
- Macro: UART_SAMPLE_FRAMER_PARITY_EN.
- Defined: an even-parity bit over the 8 data bits is sent between the last data bit and the stop bit (8E1). Byte time becomes 11*CLK_DIV, and F scales accordingly.
- Undefined: plain 8N1, and no parity logic is synthesised.

Test Plan:
- Basic frame, CLK_DIV=4, defaults: data_i=12'hABC, single valid pulse.
  - Decoded bytes 0x00, 0xAA, 0x7C; frame_done_o at cycle 121 after capture; txd idle-high afterwards.
- Multi-channel, NUM_CH=2: data_i={12'h001,12'hFFF}, two frames back-to-back with valid_i held high.
  - Frame 1: 0x00, 0xBF, 0x7F, 0x80, 0x41.
  - Frame 2 sync = 0x01.
  - Exactly one idle cycle between frames.
- Padding, DATA_W=10: data_i=10'h3FF.
  - Bytes 0x00, 0x8F, 0x7F.
- Overrun: valid_i pulsed 3 times mid-frame.
  - drop_o pulses 3 times.
  - In-flight bytes are unchanged; no new frame starts until ready_o.
- Reset mid-frame: rst asserted during the DATA bit 3 of byte 1.
  - Next edge: txd=1, ready_o=1.
  - The following frame's sync byte is 0x00.
- Parity (macro defined): data_i=12'hABC.
  - Parity bits 0, 0, 1 for the three bytes.
  - Frame length 3*11*CLK_DIV cycles.
